mc_maindec: RTL
===============

# mc_maindec

Multicycle main control FSM for the MIPS datapath. It decodes the 6-bit opcode over several cycles, sequencing fetch, decode, execute, memory and writeback. It sits directly upstream of the ALU decoder: its `aluop[1:0]` output drives that block, which combines it with `funct` to produce `alucontrol`. All other outputs drive datapath muxes and enables.

## Interface
No parameters.
- `clk` input 1: clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `op` input 6: instruction opcode (IR[31:26]), valid from DECODE onward.
- `zero` input 1: ALU zero flag, same cycle.
- `iord` output 1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite` output 1: data memory write enable.
- `irwrite` output 1: instruction register load.
- `regdst` output 1: dest reg select (0 = rt, 1 = rd).
- `memtoreg` output 1: writeback select (0 = ALUOut, 1 = MDR).
- `regwrite` output 1: register file write enable.
- `alusrca` output 1: ALU A select (0 = PC, 1 = A reg).
- `alusrcb` output 2: ALU B select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `aluop` output 2: to the ALU decoder (00 add, 01 sub, 10 funct).
- `pcsrc` output 2: next PC (00 = ALUResult, 01 = ALUOut, 10 = jump target).
- `pcen` output 1: PC enable = pcwrite | (branch & zero).
- `state` output 4: current state, for debug/verification.

## Operation
- Moore FSM. All outputs are combinational from `state`, except `pcen`, which also uses `zero`. Outputs not listed for a state are 0.
- States and encodings:
  - FETCH = 0: irwrite, pcwrite, alusrcb = 01. → DECODE.
  - DECODE = 1: alusrcb = 11. On `op`:
    - lw 100011 or sw 101011 → MEMADR.
    - R-type 000000 → RTYPEEX.
    - beq 000100 → BEQEX.
    - addi 001000 → ADDIEX (see Configuration).
    - j 000010 → JEX.
    - Any other opcode → FETCH.
  - MEMADR = 2: alusrca, alusrcb = 10. lw → MEMRD; sw → MEMWR.
  - MEMRD = 3: iord. → MEMWB.
  - MEMWB = 4: memtoreg, regwrite. → FETCH.
  - MEMWR = 5: iord, memwrite. → FETCH.
  - RTYPEEX = 6: alusrca, aluop = 10. → RTYPEWB.
  - RTYPEWB = 7: regdst, regwrite. → FETCH.
  - BEQEX = 8: alusrca, aluop = 01, pcsrc = 01, branch. → FETCH.
  - ADDIEX = 9: alusrca, alusrcb = 10. → ADDIWB.
  - ADDIWB = 10: regwrite. → FETCH.
  - JEX = 11: pcsrc = 10, pcwrite. → FETCH.
- Encodings 12–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- MEMADR selects its successor on `op` as sampled in that cycle. `op` must be held stable by the IR, since irwrite is 0 after FETCH.
- `branch` and `pcwrite` are internal signals only.

## Timing
- Reset: on a rising edge with `reset` = 1, state ← FETCH. While `reset` is high, all outputs are forced to 0, including `pcen` and `irwrite`. FETCH outputs appear in the first cycle after `reset` falls.
- Reset asserted mid-instruction abandons the instruction. No write enable is asserted in the cycle after that edge.
- Instruction latency in cycles, counted from entering FETCH to the next FETCH:
  - lw: 5.
  - sw: 4.
  - R-type: 4.
  - addi: 4.
  - beq: 3.
  - j: 3.
  - Unknown opcode: 2.
- `pcen` in BEQEX follows `zero` combinationally in the same cycle.
- Exactly one state transition per clock. There are no stalls.

## Configuration
- `MC_ADDI_EN` defined: addi (001000) follows DECODE → ADDIEX → ADDIWB → FETCH.
- `MC_ADDI_EN` undefined: the ADDIEX and ADDIWB states are not compiled. Opcode 001000 is treated as unknown (DECODE → FETCH, no regwrite). Encodings 9 and 10 behave like the other unreachable codes.

## Test plan
- Reset held for 2 cycles, then released → all outputs 0 during reset. Next cycle: state = 0, irwrite = 1, pcen = 1, alusrcb = 01.
- op = 100011 (lw) → states 0, 1, 2, 3, 4, 0. regwrite = 1 and memtoreg = 1 only in state 4. iord = 1 in state 3.
- op = 000000 (R-type) → states 0, 1, 6, 7, 0. aluop = 10 in state 6. regdst = 1 and regwrite = 1 in state 7.
- op = 000100 (beq) with zero = 1, then repeated with zero = 0 → in state 8, aluop = 01 and pcsrc = 01. pcen = 1 for zero = 1 and pcen = 0 for zero = 0.
- op = 001000 → with `MC_ADDI_EN`: states 0, 1, 9, 10, 0, with regwrite = 1 in state 10. Without it: states 0, 1, 0, and regwrite is never 1.
- Reset asserted while in state 5 (sw, memwrite = 1) → memwrite = 0 in the same cycle, and state = 0 after the edge.

Source files
------------

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional addi support is compiled in when MC_ADDI_EN is defined.
module mc_maindec (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] state
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
`ifdef MC_ADDI_EN
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`endif
    JEX     = 4'd11
  } state_t;

  state_t st, nxt;
  logic   pcwrite, branch;

  always_ff @(posedge clk) begin
    if (reset) st <= FETCH;
    else       st <= nxt;
  end

  // Unreachable encodings (and 9/10 without addi) fall back to FETCH.
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYP:      nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
`ifdef MC_ADDI_EN
          OP_ADDI:      nxt = ADDIEX;
`endif
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
`ifdef MC_ADDI_EN
      ADDIEX:  nxt = ADDIWB;
`endif
      default: nxt = FETCH;
    endcase
  end

  // Reset gates every output combinationally so an abandoned instruction
  // cannot write anything in the reset cycle.
  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    if (!reset) begin
      case (st)
        FETCH:   begin irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
        DECODE:  alusrcb = 2'b11;
        MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
        MEMRD:   iord = 1'b1;
        MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
        MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
        RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
        RTYPEWB: begin regdst = 1'b1; regwrite = 1'b1; end
        BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
`ifdef MC_ADDI_EN
        ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
        ADDIWB:  regwrite = 1'b1;
`endif
        JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
        default: ;
      endcase
    end
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = reset ? 4'd0 : st;

endmodule
